lsu_mem_ctrl: RTL

//  Parametrised load/store unit between the core datapath and a word-wide data memory.

---
 rtl/lsu_mem_ctrl_pkg.sv | 31 +++
 rtl/lsu_mem_ctrl_if.sv | 41 ++++
 rtl/lsu_mem_ctrl_lane_align.sv | 54 +++++
 rtl/lsu_mem_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit: RV funct3 encodings, FSM states
// and the access-size decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        BEAT0,
        BEAT1,
        WAITR,
        RESP
    } lsu_state_t;

    // Access size in bytes; the unsigned variants share the low two bits.
    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_bytes = 4'd1;
            2'b01:   size_bytes = 4'd2;
            2'b10:   size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core request/response and data-memory beat signals of the load/store unit.
// The slave modport is the unit itself; master is the core+memory environment.
interface lsu_mem_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    localparam int NB = DW / 8;

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          mem_valid;
    logic          mem_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [NB-1:0] mem_be;
    logic [DW-1:0] mem_wdata;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_valid, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/lsu_mem_ctrl_lane_align.sv
// Combinational lane steering: byte enables and shifted store data per beat,
// plus extraction and sign/zero extension of load data from a two-word window.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter  int DW = 32,
    localparam int NB = DW / 8,
    localparam int OW = $clog2(NB)
) (
    input  logic [OW-1:0] i_off,
    input  logic [2:0]    i_f3,
    input  logic          i_beat1,
    input  logic [DW-1:0] i_wdata,
    input  logic [DW-1:0] i_rdata0,
    input  logic [DW-1:0] i_rdata1,
    output logic [NB-1:0] o_be,
    output logic [DW-1:0] o_wdata,
    output logic [DW-1:0] o_rdata
);

    localparam logic [2*NB-1:0] ONE2 = 1;

    logic [2*NB-1:0] w_be_all;
    logic [2*DW-1:0] w_wd_all;
    logic [DW-1:0]   w_rd_lo;

    function automatic logic [DW-1:0] extend(input logic [DW-1:0] d, input logic [2:0] f3);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] sw;
        sb = d[7:0];
        sh = d[15:0];
        sw = d[31:0];
        case (f3)
            F3_B:    extend = DW'(sb);
            F3_H:    extend = DW'(sh);
            F3_W:    extend = DW'(sw);
            F3_BU:   extend = DW'(d[7:0]);
            F3_HU:   extend = DW'(d[15:0]);
            F3_WU:   extend = DW'(d[31:0]);
            default: extend = d;
        endcase
    endfunction

    // Lanes past the word boundary spill into the upper half and form beat 1.
    assign w_be_all = ((ONE2 << size_bytes(i_f3)) - ONE2) << i_off;
    assign w_wd_all = {{DW{1'b0}}, i_wdata} << {i_off, 3'b000};
    assign w_rd_lo  = DW'({i_rdata1, i_rdata0} >> {i_off, 3'b000});

    assign o_be    = i_beat1 ? w_be_all[2*NB-1:NB] : w_be_all[NB-1:0];
    assign o_wdata = i_beat1 ? w_wd_all[2*DW-1:DW] : w_wd_all[DW-1:0];
    assign o_rdata = extend(w_rd_lo, i_f3);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: latches one core request, issues one or two aligned memory
// beats, buffers read data and returns a single-cycle response.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter bit SPLIT_MIS = 1'b1
) (
    input logic          clk,
    input logic          rst,
    lsu_mem_ctrl_if.slave bus
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);

    lsu_state_t    r_state;
    lsu_state_t    w_next;
    logic          r_we;
    logic [2:0]    r_f3;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_err;
    logic          r_split;
    logic          r_beat1;
    logic          r_got;
    logic [DW-1:0] r_rd0;
    logic [DW-1:0] r_rd1;

    logic          w_accept;
    logic          w_illegal;
    logic          w_mis;
    logic          w_req_err;
    logic          w_capture;
    logic          w_mem_act;
    logic [4:0]    w_end;
    logic [AW-1:0] w_base;
    logic [NB-1:0] w_be;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_ld;

    assign w_accept  = bus.req_valid && (r_state == IDLE);
    assign w_illegal = (bus.req_funct3 == 3'b111) ||
                       ((DW == 32) && ((bus.req_funct3 == F3_D) || (bus.req_funct3 == F3_WU)));
    assign w_end     = 5'(bus.req_addr[OW-1:0]) + 5'(size_bytes(bus.req_funct3));
    assign w_mis     = w_end > 5'(NB);
    assign w_req_err = w_illegal || (w_mis && !SPLIT_MIS);

    // A read beat may return data in the same cycle it is accepted; r_got
    // remembers that so WAITR does not wait for a second rvalid.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) w_next = w_req_err ? RESP : BEAT0;
            end
            BEAT0, BEAT1: begin
                if (bus.mem_ready) begin
                    if (r_we) begin
                        w_next = ((r_state == BEAT0) && r_split) ? BEAT1 : RESP;
                    end else begin
                        w_next    = WAITR;
                        w_capture = bus.mem_rvalid;
                    end
                end
            end
            WAITR: begin
                if (r_got || bus.mem_rvalid) begin
                    w_capture = !r_got;
                    w_next    = (!r_beat1 && r_split) ? BEAT1 : RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_split <= 1'b0;
            r_beat1 <= 1'b0;
            r_got   <= 1'b0;
            r_rd0   <= '0;
            r_rd1   <= '0;
        end else begin
            r_state <= w_next;
            r_got   <= w_capture && (r_state != WAITR);
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_f3    <= bus.req_funct3;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_err   <= w_req_err;
                r_split <= w_mis && !w_req_err;
                r_beat1 <= 1'b0;
                r_rd0   <= '0;
                r_rd1   <= '0;
            end
            if (w_next == BEAT1) r_beat1 <= 1'b1;
            if (w_capture) begin
                if (r_beat1) r_rd1 <= bus.mem_rdata;
                else         r_rd0 <= bus.mem_rdata;
            end
        end
    end

    lsu_lane_align #(.DW(DW)) u_align (
        .i_off    (r_addr[OW-1:0]),
        .i_f3     (r_f3),
        .i_beat1  (r_beat1),
        .i_wdata  (r_wdata),
        .i_rdata0 (r_rd0),
        .i_rdata1 (r_rd1),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rdata  (w_ld)
    );

    assign w_base    = {r_addr[AW-1:OW], {OW{1'b0}}};
    assign w_mem_act = (r_state == BEAT0) || (r_state == BEAT1);

    assign bus.req_ready = (r_state == IDLE);
    assign bus.mem_valid = w_mem_act;
    assign bus.mem_we    = w_mem_act && r_we;
    assign bus.mem_addr  = !w_mem_act ? '0 : (r_beat1 ? w_base + AW'(NB) : w_base);
    assign bus.mem_be    = w_mem_act ? w_be : '0;
    assign bus.mem_wdata = w_mem_act ? w_wdata : '0;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_err   = (r_state == RESP) && r_err;
    assign bus.rsp_rdata = ((r_state == RESP) && !r_we && !r_err) ? w_ld : '0;

endmodule
